inv_cipher_iter: RTL and testbench
==================================

// Module: inv_cipher_iter
// PURPOSE
//  Iterative AES-128 inverse cipher (FIPS-197 sec 5.3): decrypts one 128-bit block per transaction.
//  Receive-side counterpart of the forward cipher pipeline; reuses its AESState/AESKey types.
//  Expands the cipher key forward into a round-key register file, then runs 10 inverse rounds, one per clock.
//  Sits between a valid/ready ciphertext source and a valid/ready plaintext sink.
// PARAMETERS
//  KEY_CACHE  1  1: skip key expansion when key equals the last expanded key; 0: always expand
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_valid   in   1    ciphertext/key offered
//  in_ready   out  1    block can accept; high only in IDLE
//  ct         in   128  ciphertext, t_opaque_AESState; state[c][r] = block byte 4c+r, byte 0 = MSB
//  key        in   128  cipher key, t_opaque_AESKey, same byte order
//  out_valid  out  1    plaintext available
//  out_ready  in   1    sink accepts plaintext
//  pt         out  128  plaintext, t_opaque_AESState
// BEHAVIOUR
//  Reset: FSM=IDLE, in_ready=1, out_valid=0, pt=0, round counter=0, cache_vld=0; round-key file not cleared.
//  Handshake: transfer when valid&ready on a rising edge. ct/key sampled only at the accept edge E0.
//  out_valid stays high, pt stable, until out_ready; out_valid never depends combinationally on out_ready.
//  FSM states / transitions:
//   IDLE: accept -> if KEY_CACHE & cache_vld & key==cached_key: state<=ct^rk[10], go ROUND
//         else rk[0]<=key, kcnt<=1, go KEXP.
//   KEXP: rk[kcnt]<=expand(rk[kcnt-1], Rcon[kcnt]); kcnt 1..10; at kcnt=10 also state<=ct_reg^rk10
//         (same-cycle combinational value), cached_key<=rk[0], cache_vld<=1, r<=9, go ROUND.
//   ROUND: r=9..1: state<=InvMixColumns(InvSubBytes(InvShiftRows(state))^rk[r]);
//          r=0: state<=InvSubBytes(InvShiftRows(state))^rk[0]; pt<=that value, go DONE.
//   DONE: out_valid=1; on out_ready -> IDLE (in_ready rises the next cycle; no same-cycle re-accept).
//  Latency from accept edge E0 to out_valid high: 20 cycles (expansion), 10 cycles (cache hit).
//  Throughput: one block per latency+2 cycles with out_ready tied high.
//  GF(2^8) arithmetic: xtime = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 0); InvMixColumns coeffs 0e,0b,0d,09 built from xtime chains, all 8-bit wide.
//  Key expansion: word3 RotWord, forward SubWord, XOR Rcon (01,02,04,08,10,20,40,80,1b,36) into byte 0.
//  Boundaries: in_valid during KEXP/ROUND/DONE is ignored (in_ready=0); ct/key may change freely.
//   Cache check uses the full 128-bit key; a one-bit difference forces expansion.
//   Reset mid-operation: immediate return to IDLE, cache_vld=0, partial result discarded, out_valid=0.
//   out_ready held low indefinitely: remain in DONE, pt unchanged.
// STRUCTURE
//  Shared package CipherNoOpaques_defs: t_opaque_AESState, t_opaque_AESKey, forward SBOX and
//   INV_SBOX [256] byte tables, RCON[10], xtime/gmul functions. FSM enum local to this module.
//  One sub-module inv_shift_rows (combinational, state in -> state out): row r rotated right by r,
//   i.e. o[c][r] = state[(c-r) mod 4][r]. InvSubBytes/InvMixColumns/expand stay as package functions.
// TESTING
//  1 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a
//    -> pt 00112233445566778899aabbccddeeff, out_valid exactly 20 cycles after accept.
//  2 FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32
//    -> pt 3243f6a8885a308d313198a2e0370734 (expansion path, key changed).
//  3 Repeat test 2 key with same ct, KEY_CACHE=1 -> same pt after 10 cycles; KEY_CACHE=0 -> 20.
//  4 out_ready low 50 cycles after test 1 result -> pt stable, in_ready=0, in_valid ignored; then release.
//  5 rst_n low at cycle 5 of ROUND -> out_valid=0, in_ready=1 next edge; next C.1 request takes 20 cycles.
//  6 Back-to-back 100 random key/ct pairs vs software reference model, random out_ready -> all match, no drops.

Source files
------------

// File: rtl/inv_cipher_iter_pkg.sv
// AES-128 shared types, byte tables and GF(2^8) helpers.
// Byte 0 of a block is its MSB; state[c][r] holds block byte 4c+r.
package CipherNoOpaques_defs;

    typedef logic [127:0] t_opaque_AESState;
    typedef logic [127:0] t_opaque_AESKey;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p = b;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic t_opaque_AESState inv_sub_bytes(input t_opaque_AESState s);
        t_opaque_AESState o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic t_opaque_AESState inv_mix_columns(input t_opaque_AESState s);
        t_opaque_AESState o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    // Next round key: RotWord+SubWord of word 3, Rcon into its top byte.
    function automatic t_opaque_AESKey expand(input t_opaque_AESKey k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/inv_cipher_iter_inv_shift_rows.sv
// AES InvShiftRows: row r of the state rotates right by r columns.
module inv_shift_rows
    import CipherNoOpaques_defs::*;
(
    input  t_opaque_AESState state,
    output t_opaque_AESState o
);

    always_comb begin
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = state[127-8*(4*((c-r+4)%4)+r) -: 8];
    end

endmodule

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 decryptor: forward key expansion into a round-key
// file, then ten inverse rounds at one per clock, valid/ready both sides.
module inv_cipher_iter
    import CipherNoOpaques_defs::*;
#(
    parameter bit KEY_CACHE = 1'b1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  t_opaque_AESState ct,
    input  t_opaque_AESKey   key,
    output logic             out_valid,
    input  logic             out_ready,
    output t_opaque_AESState pt
);

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} fsm_t;

    fsm_t             fsm;
    t_opaque_AESState st;
    t_opaque_AESState ct_reg;
    t_opaque_AESKey   rk [11];
    t_opaque_AESKey   cached_key;
    logic             cache_vld;
    logic [3:0]       kcnt;
    logic [3:0]       rnd;

    t_opaque_AESState isr;
    t_opaque_AESState isb;
    t_opaque_AESState rnd_val;
    t_opaque_AESKey   nk;
    logic             hit;

    inv_shift_rows u_isr (
        .state (st),
        .o     (isr)
    );

    assign isb = inv_sub_bytes(isr);
    assign nk  = expand(rk[kcnt - 4'd1], RCON[kcnt - 4'd1]);
    assign hit = KEY_CACHE && cache_vld && (key == cached_key);

    // The last round has no InvMixColumns.
    assign rnd_val = (rnd == 4'd0) ? (isb ^ rk[0])
                                   : inv_mix_columns(isb ^ rk[rnd]);

    // Round keys survive reset; cache_vld guards against stale content.
    always_ff @(posedge clk) begin
        if (fsm == IDLE && in_valid && !hit)
            rk[0] <= key;
        if (fsm == KEXP)
            rk[kcnt] <= nk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            pt         <= '0;
            st         <= '0;
            ct_reg     <= '0;
            cached_key <= '0;
            cache_vld  <= 1'b0;
            kcnt       <= 4'd1;
            rnd        <= 4'd0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (hit) begin
                            st  <= ct ^ rk[10];
                            rnd <= 4'd9;
                            fsm <= ROUND;
                        end else begin
                            ct_reg <= ct;
                            kcnt   <= 4'd1;
                            fsm    <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    kcnt <= kcnt + 4'd1;
                    if (kcnt == 4'd10) begin
                        st         <= ct_reg ^ nk;
                        cached_key <= rk[0];
                        cache_vld  <= 1'b1;
                        rnd        <= 4'd9;
                        fsm        <= ROUND;
                    end
                end
                ROUND: begin
                    st <= rnd_val;
                    if (rnd == 4'd0) begin
                        pt        <= rnd_val;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Directed and randomised checks of inv_cipher_iter against an
// independent forward-cipher model (sbox derived from GF inverse).
module tb_inv_cipher_iter;

    localparam logic [127:0] C1K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] BK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BCT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BPT  = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         rst_n;
    logic [127:0] ct;
    logic [127:0] key;
    logic         iv0, ir0, ov0, ordy0;
    logic         iv1, ir1, ov1, ordy1;
    logic [127:0] pt0, pt1;

    int           nchk;
    int           nerr;
    logic [127:0] mk;
    bit           mk_vld;
    logic [7:0]   sb [256];

    inv_cipher_iter #(.KEY_CACHE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv0),
        .in_ready  (ir0),
        .ct        (ct),
        .key       (key),
        .out_valid (ov0),
        .out_ready (ordy0),
        .pt        (pt0)
    );

    inv_cipher_iter #(.KEY_CACHE(1'b0)) dut_nc (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .ct        (ct),
        .key       (key),
        .out_valid (ov1),
        .out_ready (ordy1),
        .pt        (pt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] tm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    function automatic logic [127:0] enc(input logic [127:0] p, input logic [127:0] k);
        logic [127:0] w [11];
        logic [127:0] s, t;
        logic [31:0]  x;
        logic [7:0]   rc, a0, a1, a2, a3;
        w[0] = k;
        rc = 8'h01;
        for (int i = 1; i < 11; i++) begin
            x = w[i-1][31:0];
            x = {sb[x[23:16]], sb[x[15:8]], sb[x[7:0]], sb[x[31:24]]} ^ {rc, 24'h0};
            w[i][127:96] = w[i-1][127:96] ^ x;
            w[i][95:64]  = w[i-1][95:64] ^ w[i][127:96];
            w[i][63:32]  = w[i-1][63:32] ^ w[i][95:64];
            w[i][31:0]   = w[i-1][31:0] ^ w[i][63:32];
            rc = tm(rc, 8'h02);
        end
        s = p ^ w[0];
        for (int rd = 1; rd < 11; rd++) begin
            t = '0;
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[127-8*(4*c+r) -: 8] = sb[s[127-8*(4*((c+r)%4)+r) -: 8]];
            if (rd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[127-32*c -: 8];
                    a1 = t[119-32*c -: 8];
                    a2 = t[111-32*c -: 8];
                    a3 = t[103-32*c -: 8];
                    t[127-32*c -: 8] = tm(a0, 8'h02) ^ tm(a1, 8'h03) ^ a2 ^ a3;
                    t[119-32*c -: 8] = a0 ^ tm(a1, 8'h02) ^ tm(a2, 8'h03) ^ a3;
                    t[111-32*c -: 8] = a0 ^ a1 ^ tm(a2, 8'h02) ^ tm(a3, 8'h03);
                    t[103-32*c -: 8] = tm(a0, 8'h03) ^ a1 ^ a2 ^ tm(a3, 8'h02);
                end
            end
            s = t ^ w[rd];
        end
        return s;
    endfunction

    // One transaction: offer, time to out_valid, optional stall, drain.
    task automatic xfer(input bit sel, input logic [127:0] c, input logic [127:0] k,
                        input logic [127:0] e, input int lat, input string tag,
                        input bit rr, input int hold);
        int n;
        int t;
        bit r;
        @(negedge clk);
        ct = c;
        key = k;
        if (sel) iv1 = 1'b1;
        else iv0 = 1'b1;
        t = 0;
        while (!(sel ? ir1 : ir0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        iv1 = 1'b0;
        n = 0;
        while (!(sel ? ov1 : ov0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 128'(n), 128'(lat));
        if (!sel) begin
            mk = k;
            mk_vld = 1'b1;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            iv0 = 1'b1;
            ct = ~c;
            key = ~k;
            chk({tag, "_hold_pt"}, pt0, e);
            chk({tag, "_hold_ir"}, 128'(ir0), 128'(0));
        end
        iv0 = 1'b0;
        t = 0;
        r = 1'b0;
        while (!r && t < 300) begin
            @(negedge clk);
            r = rr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel) ordy1 = r;
            else ordy0 = r;
            t++;
        end
        chk({tag, "_valid"}, 128'(sel ? ov1 : ov0), 128'(1));
        chk({tag, "_pt"}, sel ? pt1 : pt0, e);
        @(posedge clk);
        #1;
        ordy0 = 1'b0;
        ordy1 = 1'b0;
        chk({tag, "_ovlow"}, 128'(sel ? ov1 : ov0), 128'(0));
        chk({tag, "_irhigh"}, 128'(sel ? ir1 : ir0), 128'(1));
    endtask

    initial begin
        logic [7:0]   inv, x1, x2, x3, x4;
        logic [127:0] p, k, c;
        int           t;
        int           lat;
        nchk = 0;
        nerr = 0;
        rst_n = 1'b0;
        iv0 = 1'b0;
        iv1 = 1'b0;
        ordy0 = 1'b0;
        ordy1 = 1'b0;
        ct = '0;
        key = '0;
        mk = '0;
        mk_vld = 1'b0;
        k = '0;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (tm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            x1 = rl(inv);
            x2 = rl(x1);
            x3 = rl(x2);
            x4 = rl(x3);
            sb[a] = inv ^ x1 ^ x2 ^ x3 ^ x4 ^ 8'h63;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ir", 128'(ir0), 128'(1));
        chk("rst_ov", 128'(ov0), 128'(0));
        chk("rst_pt", pt0, 128'(0));
        chk("rst_ir_nc", 128'(ir1), 128'(1));
        chk("rst_ov_nc", 128'(ov1), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;

        xfer(1'b0, C1CT, C1K, C1PT, 20, "t1", 1'b0, 50);
        xfer(1'b0, BCT, BK, BPT, 20, "t2", 1'b0, 0);
        xfer(1'b0, BCT, BK, BPT, 10, "t3_hit", 1'b0, 0);
        xfer(1'b1, BCT, BK, BPT, 20, "t3_nc_a", 1'b0, 0);
        xfer(1'b1, BCT, BK, BPT, 20, "t3_nc_b", 1'b0, 0);

        // Abort mid-ROUND with a key that would otherwise be cached.
        @(negedge clk);
        ct = C1CT;
        key = C1K;
        iv0 = 1'b1;
        t = 0;
        while (!ir0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("t5_pre_ir", 128'(ir0), 128'(0));
        rst_n = 1'b0;
        #1;
        chk("t5_async_ov", 128'(ov0), 128'(0));
        chk("t5_async_ir", 128'(ir0), 128'(1));
        @(posedge clk);
        #1;
        chk("t5_edge_ov", 128'(ov0), 128'(0));
        chk("t5_edge_ir", 128'(ir0), 128'(1));
        chk("t5_edge_pt", pt0, 128'(0));
        mk_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, C1CT, C1K, C1PT, 20, "t5", 1'b0, 0);

        for (int i = 0; i < 100; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            if (i % 4 != 3) k = {$urandom, $urandom, $urandom, $urandom};
            if (i % 8 == 5) k = mk ^ 128'h1;
            c = enc(p, k);
            lat = (mk_vld && k == mk) ? 10 : 20;
            xfer(1'b0, c, k, p, lat, $sformatf("t6_%0d", i), 1'b1, 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
